// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - memory-backed AXI4 slave with independent write/read burst FSMs
// Optional feature: define AXI_MEM_RESP_DECERR_EN to answer DECERR for words beyond MEM_DEPTH.
module axi_mem_responder #(
  parameter int AW_WIDTH   = 32,
  parameter int LEN        = 8,
  parameter int DATA_WIDTH = 32,
  parameter int X          = 16,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                    axi_clk,
  input  logic                    rst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [AW_WIDTH-1:0]     awaddr,
  input  logic [1:0]              awburst,
  input  logic [X-1:0]            awid,
  input  logic [LEN-1:0]          awlen,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic                    wlast,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bwvalid,
  input  logic                    bwready,
  output logic [1:0]              bresp,
  output logic [X-1:0]            bid,
  input  logic                    arvalid,
  output logic                    aready,
  input  logic [AW_WIDTH-1:0]     araddr,
  input  logic [1:0]              arburst,
  input  logic [X-1:0]            arid,
  input  logic [LEN-1:0]          arlen,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    rlast,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [X-1:0]            rid,
  output logic [1:0]              rresp
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int BSH = $clog2(NB);
  localparam int IW  = $clog2(MEM_DEPTH);
`ifdef AXI_MEM_RESP_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t       w_state, w_next;
  logic [X-1:0]   w_id;
  logic [LEN-1:0] w_len, w_cnt;
  logic [IW-1:0]  w_idx;
  logic           w_fixed, w_bad, w_over, w_lerr;
  logic           aw_hs, w_hs, b_hs, w_last_beat, aw_over, w_cross;
  logic [1:0]     w_resp;

  r_state_t       r_state, r_next;
  logic [LEN-1:0] r_len, r_cnt, r_cnt_inc;
  logic [IW-1:0]  r_idx, r_nidx, ar_idx;
  logic           r_fixed, r_bad, r_over, r_nover;
  logic           ar_hs, r_hs, r_last_beat, ar_over;

  assign aw_hs       = awvalid & awready;
  assign w_hs        = wvalid & wready;
  assign b_hs        = bwvalid & bwready;
  assign w_last_beat = (w_cnt == w_len);
  // Start word beyond the array, or an INCR step off the top of it, only matters with DECERR enabled.
  assign aw_over     = DECERR_EN && ((awaddr >> (BSH + IW)) != '0);
  assign w_cross     = DECERR_EN && !w_fixed && (&w_idx);

  assign ar_hs       = arvalid & aready;
  assign r_hs        = rvalid & rready;
  assign r_last_beat = (r_cnt == r_len);
  assign r_cnt_inc   = r_cnt + 1'b1;
  assign ar_idx      = araddr[BSH +: IW];
  assign ar_over     = DECERR_EN && ((araddr >> (BSH + IW)) != '0);

  // Write state register.
  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // Write next state and the response code for the final beat (includes that beat's wlast).
  always_comb begin
    w_next = w_state;
    w_resp = 2'b00;
    if (w_bad)                 w_resp = 2'b10;
    else if (w_over)           w_resp = 2'b11;
    else if (w_lerr || !wlast) w_resp = 2'b10;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write handshake outputs are registered from the next state so none depend on incoming valids.
  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bwvalid <= 1'b0;
      bid     <= '0;
      bresp   <= 2'b00;
    end else begin
      awready <= (w_next == W_IDLE);
      wready  <= (w_next == W_DATA);
      bwvalid <= (w_next == W_RESP);
      if (w_hs && w_last_beat) begin
        bid   <= w_id;
        bresp <= w_resp;
      end
    end
  end

  // Write burst bookkeeping: latch AW fields, then count beats and track sticky errors.
  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      w_id    <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_idx   <= '0;
      w_fixed <= 1'b0;
      w_bad   <= 1'b0;
      w_over  <= 1'b0;
      w_lerr  <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= awid;
      w_len   <= awlen;
      w_cnt   <= '0;
      w_idx   <= awaddr[BSH +: IW];
      w_fixed <= (awburst == 2'b00);
      w_bad   <= awburst[1];
      w_over  <= aw_over;
      w_lerr  <= 1'b0;
    end else if (w_hs) begin
      w_cnt <= w_cnt + 1'b1;
      if (wlast != w_last_beat) w_lerr <= 1'b1;
      if (!w_fixed) w_idx <= w_idx + 1'b1;
      if (w_cross) w_over <= 1'b1;
    end
  end

  // Array write port: byte-enabled, suppressed for errored bursts; contents are never reset.
  always_ff @(posedge axi_clk) begin
    if (w_hs && !w_bad && !w_over) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read state register.
  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // Read next state plus the index/error status of the following beat.
  always_comb begin
    r_next  = r_state;
    r_nidx  = r_fixed ? r_idx : r_idx + 1'b1;
    r_nover = r_over | (DECERR_EN && !r_fixed && (&r_idx));
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read handshake outputs, registered from the next state.
  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      aready <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      aready <= (r_next == R_IDLE);
      rvalid <= (r_next == R_DATA);
    end
  end

  // Read beat register: loads beat 0 on AR, the next beat on each non-final R handshake, else holds.
  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      rid     <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_fixed <= 1'b0;
      r_bad   <= 1'b0;
      r_over  <= 1'b0;
      rdata   <= '0;
      rresp   <= 2'b00;
      rlast   <= 1'b0;
    end else if (ar_hs) begin
      rid     <= arid;
      r_len   <= arlen;
      r_cnt   <= '0;
      r_idx   <= ar_idx;
      r_fixed <= (arburst == 2'b00);
      r_bad   <= arburst[1];
      r_over  <= ar_over;
      rlast   <= (arlen == '0);
      rresp   <= arburst[1] ? 2'b10 : (ar_over ? 2'b11 : 2'b00);
      rdata   <= (arburst[1] || ar_over) ? '0 : mem[ar_idx];
    end else if (r_hs && !r_last_beat) begin
      r_cnt  <= r_cnt_inc;
      r_idx  <= r_nidx;
      r_over <= r_nover;
      rlast  <= (r_cnt_inc == r_len);
      rresp  <= r_bad ? 2'b10 : (r_nover ? 2'b11 : 2'b00);
      rdata  <= (r_bad || r_nover) ? '0 : mem[r_nidx];
    end
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - scoreboard bench for axi_mem_responder
module tb_axi_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic [1:0]  awburst = 2'b01;
  logic [15:0] awid = '0;
  logic [7:0]  awlen = '0;
  logic        wvalid = 1'b0, wready, wlast = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bwvalid, bwready = 1'b0;
  logic [1:0]  bresp;
  logic [15:0] bid;
  logic        arvalid = 1'b0, aready;
  logic [31:0] araddr = '0;
  logic [1:0]  arburst = 2'b01;
  logic [15:0] arid = '0;
  logic [7:0]  arlen = '0;
  logic        rvalid, rready = 1'b0, rlast;
  logic [31:0] rdata;
  logic [15:0] rid;
  logic [1:0]  rresp;

  axi_mem_responder dut (
    .axi_clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awburst(awburst),
    .awid(awid), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
    .bwvalid(bwvalid), .bwready(bwready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .aready(aready), .araddr(araddr), .arburst(arburst),
    .arid(arid), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata), .rid(rid), .rresp(rresp)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mdl  [256];
  logic [31:0] wbuf [16];
  logic [34:0] rq [$];
  logic [17:0] bq [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [15:0] id, input logic [3:0] strb, input int bad_last);
    int          idx, n;
    logic        over;
    logic [1:0]  resp;
    logic [17:0] e;
    idx  = int'((addr >> 2) & 32'hFF);
    over = 1'b0;
`ifdef AXI_MEM_RESP_DECERR_EN
    over = ((addr >> 10) != 0);
`endif
    resp = burst[1] ? 2'b10 : (over ? 2'b11 : ((bad_last >= 0) ? 2'b10 : 2'b00));
    bq.push_back({id, resp});
    if (!burst[1] && !over) begin
      for (int i = 0; i <= len; i++) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) mdl[idx][b*8 +: 8] = wbuf[i][b*8 +: 8];
        if (burst == 2'b01) idx = (idx + 1) % 256;
      end
    end
    awaddr = addr; awlen = len[7:0]; awburst = burst; awid = id; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    chk("aw_ready", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = wbuf[i]; wstrb = strb; wlast = (i == len) ^ (i == bad_last); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(posedge clk); #1; n++; end
      chk("w_ready", wready, 1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("b_latency", bwvalid, 1);
    bwready = 1'b1;
    n = 0;
    while (!bwvalid && n < 50) begin @(posedge clk); #1; n++; end
    e = bq.pop_front();
    chk("bid", bid, e[17:2]);
    chk("bresp", bresp, e[1:0]);
    @(posedge clk); #1;
    bwready = 1'b0;
    chk("b_drop", bwvalid, 0);
    chk("aw_return", awready, 1);
  endtask

  task automatic rd_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [15:0] id, input bit stall);
    int          idx, n;
    logic        over, last;
    logic [31:0] d;
    logic [1:0]  resp;
    logic [34:0] e;
    idx  = int'((addr >> 2) & 32'hFF);
    over = 1'b0;
`ifdef AXI_MEM_RESP_DECERR_EN
    over = ((addr >> 10) != 0);
`endif
    for (int i = 0; i <= len; i++) begin
      d    = (burst[1] || over) ? 32'h0 : mdl[idx];
      resp = burst[1] ? 2'b10 : (over ? 2'b11 : 2'b00);
      last = (i == len);
      rq.push_back({last, resp, d});
      if (burst == 2'b01) idx = (idx + 1) % 256;
    end
    araddr = addr; arlen = len[7:0]; arburst = burst; arid = id; arvalid = 1'b1;
    n = 0;
    while (!aready && n < 50) begin @(posedge clk); #1; n++; end
    chk("ar_ready", aready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("r_latency", rvalid, 1);
    n = 0;
    while (rq.size() != 0 && n < 200) begin
      rready = stall ? (n % 2 == 0) : 1'b1;
      if (rvalid) begin
        e = rq[0];
        chk("rdata", rdata, e[31:0]);
        chk("rresp", rresp, e[33:32]);
        chk("rlast", rlast, e[34]);
        chk("rid", rid, id);
        if (rready) void'(rq.pop_front());
      end
      @(posedge clk); #1;
      n++;
    end
    rready = 1'b0;
    chk("r_drain", rq.size(), 0);
    rq.delete();
    chk("r_drop", rvalid, 0);
    chk("ar_return", aready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_aready", aready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bwvalid", bwvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    #1;
    chk("rel_awready0", awready, 0);
    @(posedge clk); #1;
    chk("rel_awready1", awready, 1);
    chk("rel_aready1", aready, 1);

    // Known contents for words 0..15.
    for (int i = 0; i < 16; i++) wbuf[i] = 32'h1000_0000 + i * 32'h0101;
    wr_burst(32'h0, 15, 2'b01, 16'h1, 4'hF, -1);
    rd_burst(32'h0, 15, 2'b01, 16'h1, 1'b0);

    // Single write then read.
    wbuf[0] = 32'hDEADBEEF;
    wr_burst(32'h10, 0, 2'b01, 16'h3, 4'hF, -1);
    rd_burst(32'h10, 0, 2'b01, 16'h3, 1'b0);

    // INCR burst, read back with rready toggling.
    for (int i = 0; i < 4; i++) wbuf[i] = i + 1;
    wr_burst(32'h0, 3, 2'b01, 16'h7, 4'hF, -1);
    rd_burst(32'h0, 3, 2'b01, 16'h7, 1'b1);

    // Byte strobes.
    wbuf[0] = 32'hFFFFFFFF;
    wr_burst(32'h20, 0, 2'b01, 16'h8, 4'hF, -1);
    wbuf[0] = 32'h00000000;
    wr_burst(32'h20, 0, 2'b01, 16'h8, 4'h5, -1);
    rd_burst(32'h20, 0, 2'b01, 16'h8, 1'b0);
    wbuf[0] = 32'h12345678;
    wr_burst(32'h24, 0, 2'b01, 16'h8, 4'h0, -1);
    rd_burst(32'h24, 0, 2'b01, 16'h8, 1'b0);

    // Early wlast on beat 1 of a len-3 burst.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA000_0000 + i;
    wr_burst(32'h30, 3, 2'b01, 16'h9, 4'hF, 1);
    rd_burst(32'h30, 3, 2'b01, 16'h9, 1'b1);

    // Unsupported burst type: SLVERR, no write, zero read data.
    wbuf[0] = 32'hBADBAD00;
    wr_burst(32'h10, 0, 2'b10, 16'h4, 4'hF, -1);
    rd_burst(32'h10, 0, 2'b01, 16'h4, 1'b0);
    rd_burst(32'h10, 1, 2'b11, 16'h5, 1'b0);

    // FIXED burst holds the word index.
    wbuf[0] = 32'hC0C0_0001; wbuf[1] = 32'hC0C0_0002; wbuf[2] = 32'hC0C0_0003;
    wr_burst(32'h40, 2, 2'b00, 16'hA, 4'hF, -1);
    rd_burst(32'h40, 1, 2'b00, 16'hA, 1'b1);

`ifndef AXI_MEM_RESP_DECERR_EN
    // INCR wrap from the top word back to word 0.
    wbuf[0] = 32'h5555_00FF; wbuf[1] = 32'h5555_0100;
    wr_burst(32'h3FC, 1, 2'b01, 16'hB, 4'hF, -1);
    rd_burst(32'h3FC, 1, 2'b01, 16'hB, 1'b0);
`endif

    // Address above the array: aliases to word 0, or DECERR when enabled.
    rd_burst(32'h400, 0, 2'b01, 16'h2, 1'b0);

    // Reset during beat 2 of a len-7 read.
    araddr = 32'h0; arlen = 8'd7; arburst = 2'b01; arid = 16'h55; arvalid = 1'b1;
    chk("mr_aready", aready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mr_beat2", rdata, mdl[2]);
    rst = 1'b1;
    #1;
    chk("mr_rvalid", rvalid, 0);
    chk("mr_rdata", rdata, 0);
    chk("mr_rlast", rlast, 0);
    chk("mr_aready0", aready, 0);
    rready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mr_rel_aready0", aready, 0);
    @(posedge clk); #1;
    chk("mr_rel_aready1", aready, 1);
    chk("mr_rel_awready1", awready, 1);
    rd_burst(32'h0, 7, 2'b01, 16'h56, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

- Memory-backed AXI4 slave sitting directly downstream of the `axi_m` bus, on the responder side of the agent.
- Accepts write bursts (AW/W, answers on B) and read bursts (AR, answers on R) into an internal word array, so `axi_m` initiator sequences can run end-to-end without an external DUT.
- Write and read paths are independent FSMs, each with one outstanding burst.
- Signal names match the `axi_m` bus exactly; the top level ties off unused `axi_m` sideband signals (cache/prot/qos/region/lock/user/wid).

## Interface

**Parameters**
- `AW_WIDTH`, 32 — address width.
- `LEN`, 8 — burst-length field width.
- `DATA_WIDTH`, 32 — data width; a power of 2, ≥ 8.
- `X`, 16 — ID width.
- `MEM_DEPTH`, 256 — array depth in `DATA_WIDTH` words; a power of 2.

**Ports** (one clock, `axi_clk`; reset is asynchronous and active-high, `rst`)
- `axi_clk` in 1 — clock; all logic on the rising edge.
- `rst` in 1 — asynchronous active-high reset.
- `awvalid` in 1 / `awready` out 1 — write-address handshake.
- `awaddr` in `AW_WIDTH` — byte address of the first beat.
- `awburst` in 2 — 00 FIXED, 01 INCR, others unsupported.
- `awid` in `X` / `awlen` in `LEN` — write ID; beats−1.
- `wvalid` in 1 / `wready` out 1 — write-data handshake.
- `wlast` in 1 — last write beat marker from the initiator.
- `wdata` in `DATA_WIDTH` / `wstrb` in `DATA_WIDTH/8` — write data and byte enables.
- `bwvalid` out 1 / `bwready` in 1 — write-response handshake.
- `bresp` out 2 / `bid` out `X` — write response code and ID (`bid` = `awid`).
- `arvalid` in 1 / `aready` out 1 — read-address handshake.
- `araddr` in `AW_WIDTH` / `arburst` in 2 — read address and burst type (same encoding as `awburst`).
- `arid` in `X` / `arlen` in `LEN` — read ID; beats−1.
- `rvalid` out 1 / `rready` in 1 — read-data handshake.
- `rlast` out 1 — high on beat `arlen`.
- `rdata` out `DATA_WIDTH` — read data.
- `rid` out `X` / `rresp` out 2 — read ID and response code.

## Operation

**Addressing**
- Only full-width beats are supported.
- Word index = `addr >> log2(DATA_WIDTH/8)`, taken modulo `MEM_DEPTH`.
- INCR adds 1 to the index per beat and wraps modulo `MEM_DEPTH`; FIXED holds the index.
- Burst type 10 or 11 → SLVERR (2'b10) for the whole burst; the array is not written and read data is 0.

**Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE**
- W_IDLE: `awready`=1. On `awvalid&awready`, latch id/addr/len/burst, clear the beat counter, go to W_DATA.
- W_DATA: `wready`=1. Each `wvalid&wready` writes the bytes selected by `wstrb` (`wstrb`=0 writes nothing) and increments the counter.
  - When the handshake at counter == len completes, go to W_RESP.
  - `wlast` that disagrees with the counter sets a sticky SLVERR flag; the burst still ends by count.
- W_RESP: `bwvalid`=1, `bid`=latched id, `bresp`=00 or 10. On `bwready`, return to W_IDLE.

**Read FSM: R_IDLE → R_DATA → R_IDLE**
- R_IDLE: `aready`=1. On `arvalid&aready`, latch fields and load beat 0 into the registered `rdata`.
- R_DATA: `rvalid`=1.
  - On `rvalid&rready`: if counter == len, go to R_IDLE; otherwise load the next beat.
  - `rdata`/`rid`/`rresp`/`rlast` stay stable while `rvalid&!rready`.

**Collisions**
- Simultaneous write beat and read load to the same word: the read returns the old data, and the write is committed.

## Timing

**Reset**
- Every output is 0 during and after reset.
- `awready`/`aready` (registered) rise 1 cycle after `rst` deasserts.
- Array contents are not reset.
- Reset mid-burst aborts both FSMs to IDLE; beats already written stay in the array.

**Write latency**
- AW accepted at edge N → `wready` high from N+1.
- Last W beat at edge M → `bwvalid` high from M+1.
- After the `bwready` handshake, `awready` is high the next cycle (1 bubble between write bursts).

**Read latency**
- AR accepted at edge N → `rvalid` with beat 0 from N+1.
- With `rready`=1, one beat per cycle.
- `aready` returns the cycle after the `rlast` handshake.

**Handshakes**
- A valid is never withdrawn before its handshake completes.
- Ready signals do not depend combinationally on valid inputs.

## Configuration

- Macro: `AXI_MEM_RESP_DECERR_EN`.
- **Defined:** a burst whose start word index is ≥ `MEM_DEPTH` returns DECERR (2'b11) for the whole burst.
  - The array is not written; read data is 0.
  - An INCR burst that crosses `MEM_DEPTH` returns DECERR from the crossing beat onward.
- **Undefined:** address bits above the array index are ignored; all addresses alias modulo `MEM_DEPTH`.

## Test plan

- **Single write then read:** AW addr 0x10, len 0, INCR, id 3; W 0xDEADBEEF, strb 0xF. → B: `bid`=3, `bresp`=00 at AW+2. AR 0x10 → `rdata`=0xDEADBEEF, `rlast`=1, `rresp`=00.
- **INCR burst with back-pressure:** write len 3 at 0x0, data 1..4. Read back with `rready` toggling 1/0. → Beats 1,2,3,4 in order, each stable while stalled; `rlast` only on beat 4.
- **Byte strobes:** write 0xFFFFFFFF to 0x20, then write 0x00000000 with strb 0x5. → Readback 0xFF00FF00.
- **Protocol errors:**
  - `wlast` asserted on beat 1 of a len-3 burst → `bresp`=10 after beat 4.
  - `awburst`=10 → `bresp`=10, array unchanged.
- **Reset mid-read:** `rst` asserted during beat 2 of a len-7 read. → `rvalid`=0 immediately; `aready`=1 one cycle after release; a fresh read returns correct data.
- **Addressing with `AXI_MEM_RESP_DECERR_EN`:** AR 0x400 with `MEM_DEPTH`=256, 32-bit data. → `rresp`=11, `rdata`=0. Without the macro: the same read returns word 0.
